// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with a 2-entry skid buffer (registered in_ready)
// and a saturating stall counter for hazard/performance debug.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 101,
  parameter int unsigned CTRL_W = 7,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_stats
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                accept, fire;

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (state_q != S_TWO) & ~rst;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign stall_cnt = stall_cnt_q;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid_q & out_ready;

  // Occupancy and storage update; main_ctrl is zeroed whenever the stage goes empty.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d     = S_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        S_ONE: begin
          if (accept && fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            state_d     = S_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (fire) begin
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    if (state_d == S_EMPTY) begin
      main_ctrl_d = '0;
    end
    out_valid_d = (state_d != S_EMPTY);
  end

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (stall counter narrowed to 4 bits
// so saturation is reachable).
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 101;
  localparam int unsigned CTRL_W = 7;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic              clr_stats;

  int n_checks;
  int n_fail;

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt),
    .clr_stats(clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DATA_W-1:0] d,
                           input logic [CTRL_W-1:0] c);
    check({tag, ".valid"}, 128'(out_valid), 128'(v));
    check({tag, ".data"},  128'(out_data),  128'(d));
    check({tag, ".ctrl"},  128'(out_ctrl),  128'(c));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    clr_stats = 1'b0;

    // Reset
    cycle();
    cycle();
    check("rst.in_ready", 128'(in_ready), 128'(0));
    check_out("rst", 1'b0, '0, '0);
    check("rst.stall", 128'(stall_cnt), 128'(0));
    rst = 1'b0;
    #1;
    check("rst.in_ready_after", 128'(in_ready), 128'(1));

    // Streaming with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i);
      in_ctrl  = 7'h41;
      #1;
      check($sformatf("stream%0d.in_ready", i), 128'(in_ready), 128'(1));
      cycle();
      check_out($sformatf("stream%0d", i), 1'b1, DATA_W'(i), 7'h41);
    end
    in_valid = 1'b0;
    cycle();
    check_out("stream.drain", 1'b0, DATA_W'(8), '0);
    check("stream.stall", 128'(stall_cnt), 128'(0));

    // Back-pressure: A to main, B to skid, C refused
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'('hA);
    in_ctrl   = 7'h01;
    cycle();
    check_out("bp.A", 1'b1, DATA_W'('hA), 7'h01);
    check("bp.A.in_ready", 128'(in_ready), 128'(1));
    check("bp.A.stall", 128'(stall_cnt), 128'(0));
    in_data = DATA_W'('hB);
    in_ctrl = 7'h02;
    cycle();
    check_out("bp.B", 1'b1, DATA_W'('hA), 7'h01);
    check("bp.B.in_ready", 128'(in_ready), 128'(0));
    check("bp.B.stall", 128'(stall_cnt), 128'(1));
    in_data = DATA_W'('hC);
    in_ctrl = 7'h03;
    cycle();
    check("bp.C.in_ready", 128'(in_ready), 128'(0));
    check("bp.C.stall", 128'(stall_cnt), 128'(2));
    cycle();
    check("bp.C2.stall", 128'(stall_cnt), 128'(3));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    check_out("bp.outB", 1'b1, DATA_W'('hB), 7'h02);
    check("bp.outB.in_ready", 128'(in_ready), 128'(1));
    check("bp.outB.stall", 128'(stall_cnt), 128'(3));
    in_valid = 1'b1;
    cycle();
    check_out("bp.outC", 1'b1, DATA_W'('hC), 7'h03);
    in_valid = 1'b0;
    cycle();
    check_out("bp.drain", 1'b0, DATA_W'('hC), '0);

    // Flush while holding two entries; D must be discarded
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'('hA);
    in_ctrl   = 7'h11;
    cycle();
    in_data = DATA_W'('hB);
    in_ctrl = 7'h22;
    cycle();
    check("fl.full.in_ready", 128'(in_ready), 128'(0));
    flush   = 1'b1;
    in_data = DATA_W'('hD);
    in_ctrl = 7'h55;
    cycle();
    check_out("fl", 1'b0, DATA_W'('hA), '0);
    check("fl.in_ready", 128'(in_ready), 128'(1));
    check("fl.stall_kept", 128'(stall_cnt), 128'(5));
    flush    = 1'b0;
    in_valid = 1'b0;
    cycle();
    check_out("fl.after", 1'b0, DATA_W'('hA), '0);

    // Bubble: stale data with ctrl 7F must show ctrl 0 once invalid
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = DATA_W'('h77);
    in_ctrl   = 7'h7F;
    cycle();
    check_out("bub.load", 1'b1, DATA_W'('h77), 7'h7F);
    in_valid = 1'b0;
    cycle();
    check_out("bub.idle", 1'b0, DATA_W'('h77), '0);
    cycle();
    check_out("bub.idle2", 1'b0, DATA_W'('h77), '0);

    // Counter saturation and clear priority
    clr_stats = 1'b1;
    cycle();
    check("sat.clr", 128'(stall_cnt), 128'(0));
    clr_stats = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'('h5);
    in_ctrl   = 7'h05;
    cycle();
    in_valid = 1'b0;
    check("sat.start", 128'(stall_cnt), 128'(0));
    for (int i = 0; i < 20; i++) cycle();
    check("sat.15", 128'(stall_cnt), 128'(15));
    clr_stats = 1'b1;
    cycle();
    check("sat.clr_vs_inc", 128'(stall_cnt), 128'(0));
    clr_stats = 1'b0;
    cycle();
    check("sat.resume", 128'(stall_cnt), 128'(1));

    // Reset while in TWO
    in_valid = 1'b1;
    in_data  = DATA_W'('h6);
    in_ctrl  = 7'h06;
    cycle();
    check("rmid.full", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    rst      = 1'b1;
    flush    = 1'b1;
    #1;
    check("rmid.in_ready_rst", 128'(in_ready), 128'(0));
    cycle();
    check_out("rmid", 1'b0, '0, '0);
    check("rmid.stall", 128'(stall_cnt), 128'(0));
    check("rmid.in_ready_hold", 128'(in_ready), 128'(0));
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    check("rmid.in_ready_after", 128'(in_ready), 128'(1));
    cycle();
    check_out("rmid.empty", 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
